axis_split_multi_channel: RTL and testbench
===========================================

# axis_split_multi_channel

Splits each AXI-stream packet on one slave port into up to NUM consecutive segments, each routed to its own master channel and terminated with a generated tlast. Segment lengths for channels 0..NUM-2 are programmable and latched per packet. Channel NUM-1 takes the remainder. It replaces the fixed two-way head/tail split in the stream-processing datapath, adds zero-length segment skipping and a short-packet flag, and drives its outputs from registers.

## Interface
- DSIZE, 32: tdata width in bits; tkeep width is DSIZE/8.
- NUM, 4: number of output channels, 2..16.
- LSIZE, 16: segment length and beat counter width.
- aclk  in  1  sole clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- split_len  in  (NUM-1)*LSIZE  slice i = beat count of segment i; sampled on the first beat of each packet.
- s_axis_tdata / tkeep / tuser / tvalid / tlast  in  DSIZE / DSIZE/8 / 1 / 1 / 1  slave stream.
- s_axis_tready  out  1  slave ready.
- m_axis_tdata / tkeep / tuser  out  NUM*DSIZE / NUM*DSIZE/8 / NUM  per-channel payload; slice i belongs to channel i.
- m_axis_tvalid / tlast  out  NUM / NUM  per-channel valid and tlast.
- m_axis_tready  in  NUM  per-channel ready.
- busy  out  1  a packet is in progress (SOP accepted, original tlast not yet accepted).
- short_pkt  out  1  one-cycle pulse: original tlast accepted while seg < NUM-1 and the current segment's count is not exhausted.

## Operation
- State: sop flag (reset 1), seg index, log2(NUM) bits (reset 0), beat counter cnt, LSIZE bits (reset 0), latched lengths len_q (reset 0), output register {valid, dest, data, keep, user, last}.
- Accept: beat is accepted when s_axis_tvalid & s_axis_tready.
- Effective lengths: live split_len when sop=1, otherwise len_q. On an accepted SOP beat, len_q <= split_len.
- Segment select at SOP: seg = lowest i < NUM-1 with len[i] != 0; if none, seg = NUM-1.
- Per accepted beat, for seg < NUM-1:
  - If cnt == len[seg]-1: the beat gets out_last = 1. cnt <= 0. seg <= next higher i < NUM-1 with len[i] != 0, else NUM-1.
  - Otherwise: cnt <= cnt+1.
- Channel NUM-1: out_last = s_axis_tlast; cnt is not used.
- Original tlast: the beat always gets out_last = 1, on whatever segment is current. Then sop <= 1, seg and cnt are reset for the next packet, and busy falls.
- short_pkt: pulses when the original tlast lands on seg < NUM-1 and the current segment's count is not exhausted (tlast earlier than cnt == len[seg]-1). Remaining segments receive nothing.
- Exact boundary: if the original tlast coincides with a segment end on seg < NUM-1, that channel gets tlast and short_pkt does not pulse. Later channels receive nothing.
- Single-beat packet: SOP and tlast on the same beat are both handled.
- Output register: one entry, shared by all channels.
  - m_axis_tvalid[i] = out_valid & (out_dest == i).
  - Payload is replicated onto all slices; only the valid slice is meaningful.
- s_axis_tready = ~out_valid | m_axis_tready[out_dest]. This gives full throughput; the ready path from master to slave is combinational.

## Timing
- Latency: a beat accepted in cycle N is presented on its channel in cycle N+1.
- Throughput: 1 beat/cycle while the selected master is ready. Back-to-back packets need no gap cycle.
- The output register holds stable while valid & ~ready (AXI rule). Holding on one channel blocks all channels.
- split_len changes mid-packet are ignored until the next SOP.
- Reset values: s_axis_tready 0 during reset, 1 in the first cycle after. m_axis_tvalid 0, m_axis_tlast 0, busy 0, short_pkt 0, data 0.
- Reset mid-packet: the output beat is dropped. The next accepted beat is treated as SOP with freshly sampled lengths.
- len[i] wider than the packet: behaves as the short-packet case. A length of 2^LSIZE-1 is legal.

## Test plan
- NUM=4, lengths {2,3,1}, 10-beat packet D0..D9, all ready: ch0 gets D0,D1 (tlast on D1); ch1 gets D2..D4 (tlast on D4); ch2 gets D5 (tlast); ch3 gets D6..D9 (tlast on D9). short_pkt stays 0. Each beat appears one cycle after acceptance.
- Lengths {0,2,0}, 5 beats: ch0 and ch2 never valid; ch1 gets D0,D1 (tlast on D1); ch3 gets D2..D4 (tlast on D4).
- Lengths {4,4,4}, 3-beat packet: ch0 gets D0..D2 with tlast on D2; short_pkt pulses one cycle; next packet starts on ch0.
- Lengths {2,2,2}, 6-beat packet ending exactly at the ch2 boundary: tlast on D5 on ch2; ch3 idle; no short_pkt. Then change split_len mid-packet to {1,1,1}: the new lengths apply only from the next SOP.
- Random m_axis_tready stalls on ch1 during a 20-beat packet: payload is held stable while stalled; no loss or duplication (scoreboard). s_axis_tready low only while the out register is full and ch1 is stalled.
- Assert areset on beat 3 of a packet: all valids drop the next cycle, busy=0. The following packet routes from ch0 with the new lengths.

Source files
------------

// File: rtl/axis_split_multi_channel.sv
// ----------------------------------------------------------------------------
// axis_split_multi_channel
//
// Purpose:
//   Splits each AXI-stream packet arriving on the slave port into up to NUM
//   consecutive segments. Segment i (i < NUM-1) carries split_len slice i
//   beats and goes to master channel i. Channel NUM-1 carries whatever is
//   left. Every segment ends with a generated tlast. Segments with a length
//   of zero are skipped. If a packet ends before its current programmed
//   segment is full, short_pkt pulses for one cycle. Segment lengths are
//   latched on the first beat (SOP) of each packet. One output register is
//   shared by all channels, so each beat appears one cycle after it is
//   accepted.
//
// Ports:
//   aclk, areset     clock and synchronous active-high reset
//   split_len        (NUM-1) packed LSIZE-bit segment lengths, slice i = seg i
//   s_axis_*         slave stream: tdata, tkeep, tuser, tvalid, tlast, tready
//   m_axis_*         per-channel master streams; slice i belongs to channel i
//   busy             packet in progress (SOP accepted, tlast not yet accepted)
//   short_pkt        one-cycle pulse when a packet ends inside a segment
// ----------------------------------------------------------------------------
module axis_split_multi_channel #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned NUM   = 4,
  parameter int unsigned LSIZE = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [(NUM-1)*LSIZE-1:0]      split_len,
  input  logic [DSIZE-1:0]              s_axis_tdata,
  input  logic [DSIZE/8-1:0]            s_axis_tkeep,
  input  logic                          s_axis_tuser,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [NUM*DSIZE-1:0]          m_axis_tdata,
  output logic [NUM*(DSIZE/8)-1:0]      m_axis_tkeep,
  output logic [NUM-1:0]                m_axis_tuser,
  output logic [NUM-1:0]                m_axis_tvalid,
  output logic [NUM-1:0]                m_axis_tlast,
  input  logic [NUM-1:0]                m_axis_tready,
  output logic                          busy,
  output logic                          short_pkt
);

  localparam int unsigned KSIZE   = DSIZE / 8;
  localparam int unsigned SW      = $clog2(NUM);
  localparam int unsigned NLEN    = NUM - 1;
  localparam int unsigned LAST_CH = NUM - 1;

  // Packet tracking state
  logic                    r_sop;
  logic [SW-1:0]           r_seg;
  logic [LSIZE-1:0]        r_cnt;
  logic [NLEN*LSIZE-1:0]   r_len;
  logic                    r_busy;
  logic                    r_short;

  // Shared output register
  logic                    r_out_valid;
  logic [SW-1:0]           r_out_dest;
  logic [DSIZE-1:0]        r_out_data;
  logic [KSIZE-1:0]        r_out_keep;
  logic                    r_out_user;
  logic                    r_out_last;

  // Combinational helpers
  logic                    w_out_ready;
  logic                    w_ready;
  logic                    w_accept;
  logic [NLEN*LSIZE-1:0]   w_len;
  logic [SW-1:0]           w_first_seg;
  logic [SW-1:0]           w_cur_seg;
  logic [SW-1:0]           w_next_seg;
  logic [LSIZE-1:0]        w_cur_len;
  logic                    w_last_ch;
  logic                    w_seg_end;
  logic                    w_out_last;
  logic                    w_short;

  // Slave ready: output register empty or being drained this cycle
  assign w_out_ready = m_axis_tready[r_out_dest];
  assign w_ready     = ~areset & (~r_out_valid | w_out_ready);
  assign w_accept    = s_axis_tvalid & w_ready;

  // Live lengths apply on the SOP beat; latched copy for the rest of the packet
  assign w_len = r_sop ? split_len : r_len;

  // First non-empty programmed segment, falling back to the remainder channel
  always_comb begin
    w_first_seg = SW'(LAST_CH);
    for (int i = int'(NLEN) - 1; i >= 0; i--) begin
      if (w_len[i*LSIZE +: LSIZE] != '0) begin
        w_first_seg = SW'(i);
      end
    end
  end

  assign w_cur_seg = r_sop ? w_first_seg : r_seg;
  assign w_last_ch = (w_cur_seg == SW'(LAST_CH));

  // Length of the current segment (unused on the remainder channel)
  always_comb begin
    w_cur_len = '0;
    for (int i = 0; i < int'(NLEN); i++) begin
      if (w_cur_seg == SW'(i)) begin
        w_cur_len = w_len[i*LSIZE +: LSIZE];
      end
    end
  end

  // Next non-empty programmed segment above the current one
  always_comb begin
    w_next_seg = SW'(LAST_CH);
    for (int i = int'(NLEN) - 1; i >= 0; i--) begin
      if ((SW'(i) > w_cur_seg) && (w_len[i*LSIZE +: LSIZE] != '0)) begin
        w_next_seg = SW'(i);
      end
    end
  end

  // Only non-zero segments are ever selected, so len-1 cannot underflow here
  assign w_seg_end  = ~w_last_ch & (r_cnt == LSIZE'(w_cur_len - LSIZE'(1)));
  assign w_out_last = s_axis_tlast | w_seg_end;
  assign w_short    = w_accept & s_axis_tlast & ~w_last_ch & ~w_seg_end;

  // Segment tracking and output register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_sop       <= 1'b1;
      r_seg       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_busy      <= 1'b0;
      r_short     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_dest  <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_user  <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_short <= w_short;

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_dest  <= w_cur_seg;
        r_out_data  <= s_axis_tdata;
        r_out_keep  <= s_axis_tkeep;
        r_out_user  <= s_axis_tuser;
        r_out_last  <= w_out_last;

        if (r_sop) begin
          r_len <= split_len;
        end

        if (s_axis_tlast) begin
          // Packet done: rearm for the next SOP
          r_sop  <= 1'b1;
          r_seg  <= '0;
          r_cnt  <= '0;
          r_busy <= 1'b0;
        end else begin
          r_sop  <= 1'b0;
          r_busy <= 1'b1;
          if (w_seg_end) begin
            r_cnt <= '0;
            r_seg <= w_next_seg;
          end else begin
            r_seg <= w_cur_seg;
            if (!w_last_ch) begin
              r_cnt <= LSIZE'(r_cnt + LSIZE'(1));
            end
          end
        end
      end else if (r_out_valid && w_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Payload is replicated; only the slice whose tvalid is set is meaningful
  assign m_axis_tdata  = {NUM{r_out_data}};
  assign m_axis_tkeep  = {NUM{r_out_keep}};
  assign m_axis_tuser  = {NUM{r_out_user}};

  for (genvar g = 0; g < int'(NUM); g++) begin : g_ch
    assign m_axis_tvalid[g] = r_out_valid & (r_out_dest == SW'(g));
    assign m_axis_tlast[g]  = r_out_valid & r_out_last & (r_out_dest == SW'(g));
  end

  assign s_axis_tready = w_ready;
  assign busy          = r_busy;
  assign short_pkt     = r_short;

endmodule

// File: tb/tb_axis_split_multi_channel.sv
// ----------------------------------------------------------------------------
// tb_axis_split_multi_channel
//
// Purpose:
//   Self-checking bench for axis_split_multi_channel (NUM=4, DSIZE=32,
//   LSIZE=16). A table of packet vectors (lengths, beat count, expected
//   per-channel beat counts, expected short_pkt pulses) is applied in a loop.
//   A reference model pushes the expected routing of every beat into a
//   scoreboard queue; a monitor pops and compares at each handshake.
//   Hand-written sequences cover mid-packet length changes, back-to-back
//   packets and reset in the middle of a packet.
// ----------------------------------------------------------------------------
module tb_axis_split_multi_channel;

  localparam int unsigned DSIZE = 32;
  localparam int unsigned NUM   = 4;
  localparam int unsigned LSIZE = 16;
  localparam int unsigned KSIZE = DSIZE / 8;

  logic                     aclk;
  logic                     areset;
  logic [(NUM-1)*LSIZE-1:0] split_len;
  logic [DSIZE-1:0]         s_axis_tdata;
  logic [KSIZE-1:0]         s_axis_tkeep;
  logic                     s_axis_tuser;
  logic                     s_axis_tvalid;
  logic                     s_axis_tlast;
  logic                     s_axis_tready;
  logic [NUM*DSIZE-1:0]     m_axis_tdata;
  logic [NUM*KSIZE-1:0]     m_axis_tkeep;
  logic [NUM-1:0]           m_axis_tuser;
  logic [NUM-1:0]           m_axis_tvalid;
  logic [NUM-1:0]           m_axis_tlast;
  logic [NUM-1:0]           m_axis_tready;
  logic                     busy;
  logic                     short_pkt;

  axis_split_multi_channel #(.DSIZE(DSIZE), .NUM(NUM), .LSIZE(LSIZE)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .split_len     (split_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .short_pkt     (short_pkt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int          ch;
    logic [31:0] d;
    logic        last;
  } exp_t;

  typedef struct {
    logic [2:0][15:0] lens;
    int               nbeats;
    int               c0, c1, c2, c3;
    int               short_exp;
    bit               stall;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  int          ch_cnt[4];
  int          short_cnt = 0;
  bit          sb_en = 1'b1;
  bit          stall_en = 1'b0;
  logic [3:0]  hold_v = '0;
  logic [31:0] hold_d[4];
  logic [3:0]  hold_l;
  logic        exp_rdy;
  exp_t        mon_e;

  function automatic logic [31:0] beat_data(input int p, input int k);
    return {8'hA5, 8'(p), 16'(k)};
  endfunction

  // Expected routing of a packet, derived from the lengths only
  task automatic model_pkt(input logic [2:0][15:0] lens, input int n, input int p);
    int   rem;
    int   k;
    int   take;
    exp_t e;
    rem = n;
    k   = 0;
    for (int s = 0; s < 3; s++) begin
      if (lens[s] != 16'd0 && rem > 0) begin
        take = (int'(lens[s]) < rem) ? int'(lens[s]) : rem;
        for (int j = 0; j < take; j++) begin
          e.ch = s; e.d = beat_data(p, k); e.last = (j == take - 1);
          sb_q.push_back(e);
          k++;
        end
        rem -= take;
      end
    end
    for (int j = 0; j < rem; j++) begin
      e.ch = 3; e.d = beat_data(p, k); e.last = (j == rem - 1);
      sb_q.push_back(e);
      k++;
    end
  endtask

  // Drive one beat and wait (bounded) for its handshake
  task automatic send(input logic [31:0] d, input logic last);
    int          waited;
    int          vch;
    logic [31:0] got;
    s_axis_tdata  = d;
    s_axis_tkeep  = d[3:0];
    s_axis_tuser  = d[0];
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    waited = 0;
    do begin
      @(negedge aclk);
      if (!s_axis_tready) waited++;
    end while (!s_axis_tready && waited < 500);
    if (!s_axis_tready) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%h not accepted in 500 cycles", d);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    // Accepted beat must be presented exactly one cycle later
    vch = -1;
    for (int i = 0; i < 4; i++) if (m_axis_tvalid[i]) vch = i;
    got = (vch >= 0) ? m_axis_tdata[vch*32 +: 32] : 32'hxxxx_xxxx;
    checks++;
    if (vch < 0 || got !== d) begin
      errors++;
      $display("FAIL latency got valid=%b data=%h required data=%h", m_axis_tvalid, got, d);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || m_axis_tvalid != '0) && w < 300) begin
      @(negedge aclk);
      w++;
    end
    @(posedge aclk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d beats outstanding required 0", sb_q.size());
    end
  endtask

  task automatic run_vec(input vec_t v, input int p);
    int ec[4];
    ec[0] = v.c0; ec[1] = v.c1; ec[2] = v.c2; ec[3] = v.c3;
    split_len = v.lens;
    stall_en  = v.stall;
    for (int i = 0; i < 4; i++) ch_cnt[i] = 0;
    short_cnt = 0;
    model_pkt(v.lens, v.nbeats, p);
    for (int k = 0; k < v.nbeats; k++) begin
      send(beat_data(p, k), k == v.nbeats - 1);
      if (k == 0 && v.nbeats > 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid pkt=%0d got %b required 1", p, busy);
        end
      end
    end
    stall_en = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ch_cnt[i] != ec[i]) begin
        errors++;
        $display("FAIL ch_count pkt=%0d ch=%0d got %0d required %0d", p, i, ch_cnt[i], ec[i]);
      end
    end
    checks++;
    if (short_cnt != v.short_exp) begin
      errors++;
      $display("FAIL short_pkt pkt=%0d got %0d pulses required %0d", p, short_cnt, v.short_exp);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end pkt=%0d got %b required 0", p, busy);
    end
  endtask

  task automatic set_vec(input int idx, input int l0, input int l1, input int l2, input int n,
                         input int c0, input int c1, input int c2, input int c3,
                         input int sh, input bit st);
    vecs[idx].lens[0]   = 16'(l0);
    vecs[idx].lens[1]   = 16'(l1);
    vecs[idx].lens[2]   = 16'(l2);
    vecs[idx].nbeats    = n;
    vecs[idx].c0 = c0; vecs[idx].c1 = c1; vecs[idx].c2 = c2; vecs[idx].c3 = c3;
    vecs[idx].short_exp = sh;
    vecs[idx].stall     = st;
  endtask

  // Random backpressure on channel 1 only
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge aclk); #1;
      m_axis_tready = stall_en ? {2'b11, 1'($urandom_range(0, 1)), 1'b1} : 4'b1111;
    end
  end

  // Monitor: ready rule, one-hot valid, hold stability, scoreboard
  always @(negedge aclk) begin
    if (areset) begin
      hold_v = '0;
    end else begin
      exp_rdy = (m_axis_tvalid == '0) || ((m_axis_tvalid & m_axis_tready) != '0);
      checks++;
      if (s_axis_tready !== exp_rdy) begin
        errors++;
        $display("FAIL s_ready got %b required %b (valid=%b ready=%b)",
                 s_axis_tready, exp_rdy, m_axis_tvalid, m_axis_tready);
      end
      checks++;
      if ($countones(m_axis_tvalid) > 1) begin
        errors++;
        $display("FAIL onehot got valid=%b required at most one bit", m_axis_tvalid);
      end
      for (int i = 0; i < 4; i++) begin
        if (hold_v[i]) begin
          checks++;
          if (!m_axis_tvalid[i] || m_axis_tdata[i*32 +: 32] !== hold_d[i] ||
              m_axis_tlast[i] !== hold_l[i]) begin
            errors++;
            $display("FAIL hold ch=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b", i,
                     m_axis_tvalid[i], m_axis_tdata[i*32 +: 32], m_axis_tlast[i],
                     hold_d[i], hold_l[i]);
          end
        end
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          ch_cnt[i]++;
          if (sb_en) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL sb_extra ch=%0d got d=%h required no beat", i, m_axis_tdata[i*32 +: 32]);
            end else begin
              mon_e = sb_q.pop_front();
              if (mon_e.ch != i || m_axis_tdata[i*32 +: 32] !== mon_e.d ||
                  m_axis_tlast[i] !== mon_e.last ||
                  m_axis_tkeep[i*4 +: 4] !== mon_e.d[3:0] || m_axis_tuser[i] !== mon_e.d[0]) begin
                errors++;
                $display("FAIL sb_beat got ch=%0d d=%h last=%b required ch=%0d d=%h last=%b",
                         i, m_axis_tdata[i*32 +: 32], m_axis_tlast[i], mon_e.ch, mon_e.d, mon_e.last);
              end
            end
          end
        end
        hold_v[i] = m_axis_tvalid[i] & ~m_axis_tready[i];
        hold_d[i] = m_axis_tdata[i*32 +: 32];
        hold_l[i] = m_axis_tlast[i];
      end
      if (short_pkt) short_cnt++;
    end
  end

  logic [2:0][15:0] lens_v;
  vec_t             rv;

  initial begin
    // Table: lens {l0,l1,l2}, beats, expected counts ch0..ch3, short pulses, stall
    set_vec(0, 2, 3, 1, 10,   2, 3, 1, 4,   0, 1'b0);
    set_vec(1, 0, 2, 0, 5,    0, 2, 0, 3,   0, 1'b0);
    set_vec(2, 4, 4, 4, 3,    3, 0, 0, 0,   1, 1'b0);
    set_vec(3, 2, 2, 2, 6,    2, 2, 2, 0,   0, 1'b0);
    set_vec(4, 1, 1, 1, 1,    1, 0, 0, 0,   0, 1'b0);
    set_vec(5, 0, 0, 0, 3,    0, 0, 0, 3,   0, 1'b0);
    set_vec(6, 3, 0, 0, 1,    1, 0, 0, 0,   1, 1'b0);
    set_vec(7, 65535, 1, 1, 4, 4, 0, 0, 0,  1, 1'b0);
    set_vec(8, 1, 15, 2, 20,  1, 15, 2, 2,  0, 1'b1);

    areset        = 1'b1;
    split_len     = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b required 0", s_axis_tready);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready got %b required 1", s_axis_tready);
    end
    checks++;
    if (m_axis_tvalid !== 4'b0 || m_axis_tlast !== 4'b0 || busy !== 1'b0 ||
        short_pkt !== 1'b0 || m_axis_tdata !== '0) begin
      errors++;
      $display("FAIL rst_values got valid=%b last=%b busy=%b short=%b data=%h required all 0",
               m_axis_tvalid, m_axis_tlast, busy, short_pkt, m_axis_tdata);
    end
    @(posedge aclk); #1;

    for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

    // Mid-packet length change, then back-to-back packet using the new lengths
    for (int i = 0; i < 4; i++) ch_cnt[i] = 0;
    short_cnt = 0;
    lens_v[0] = 16'd2; lens_v[1] = 16'd2; lens_v[2] = 16'd2;
    split_len = lens_v;
    model_pkt(lens_v, 6, 20);
    send(beat_data(20, 0), 1'b0);
    lens_v[0] = 16'd1; lens_v[1] = 16'd1; lens_v[2] = 16'd1;
    split_len = lens_v;
    for (int k = 1; k < 6; k++) send(beat_data(20, k), k == 5);
    model_pkt(lens_v, 3, 21);
    for (int k = 0; k < 3; k++) send(beat_data(21, k), k == 2);
    drain();
    checks++;
    if (ch_cnt[0] != 3 || ch_cnt[1] != 3 || ch_cnt[2] != 3 || ch_cnt[3] != 0 || short_cnt != 0) begin
      errors++;
      $display("FAIL midchange got counts %0d/%0d/%0d/%0d short=%0d required 3/3/3/0 short=0",
               ch_cnt[0], ch_cnt[1], ch_cnt[2], ch_cnt[3], short_cnt);
    end

    // Reset on beat 3 of a packet: in-flight beat dropped, next packet is a fresh SOP
    sb_en = 1'b0;
    lens_v[0] = 16'd2; lens_v[1] = 16'd3; lens_v[2] = 16'd1;
    split_len = lens_v;
    for (int k = 0; k < 3; k++) send(beat_data(30, k), 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready got %b required 0", s_axis_tready);
    end
    @(posedge aclk); #1;
    checks++;
    if (m_axis_tvalid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got valid=%b busy=%b required 0000 0", m_axis_tvalid, busy);
    end
    areset = 1'b0;
    sb_en  = 1'b1;
    rv.lens[0] = 16'd1; rv.lens[1] = 16'd2; rv.lens[2] = 16'd0;
    rv.nbeats = 4; rv.c0 = 1; rv.c1 = 2; rv.c2 = 0; rv.c3 = 1;
    rv.short_exp = 0; rv.stall = 1'b0;
    run_vec(rv, 31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
